noc_to_axis_adapter: RTL and testbench
======================================

Name: noc_to_axis_adapter

Overview:
- Egress adapter: accepts 36-bit flits from a router_slice output port (port 4, local/ejection) and presents them as an AXI-Stream master.
- Counterpart of axis_to_noc_adapter.
- Buffers flits in a DEPTH-entry FIFO and returns one credit pulse to the router per flit drained on the AXI side.
- Tracks packet framing (head/tail) and reports protocol and credit violations as sticky flags.

Parameters:
- AXIW, 32: flit payload / tdata width.
- DEPTH, 8: receive FIFO entries; must equal the credit count the router holds for this port at reset; power of 2, ≥2.
- FLIT_W, 36: flit width = AXIW + 4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- router_in_port  input  FLIT_W  flit from router channel_out_op[port 4]; [35] valid, [34] head, [33] tail, [32] reserved (ignored), [31:0] data
- flow_ctrl_out  output  1  credit return to router flow_ctrl_in_op[port 4]; 1-cycle pulse = one buffer freed
- m_axis_tvalid  output  1  AXI-S valid
- m_axis_tready  input  1  AXI-S ready
- m_axis_tdata  output  AXIW  flit data
- m_axis_tlast  output  1  flit tail bit
- m_axis_tuser  output  1  flit head bit
- err_overflow  output  1  sticky: flit arrived while FIFO full
- err_framing  output  1  sticky: head/tail sequence violation

Behaviour:
- Reset values (registered, all cleared by rst at the clock edge):
  - flow_ctrl_out = 0, m_axis_tvalid = 0, m_axis_tdata/tlast/tuser = 0.
  - err_overflow = 0, err_framing = 0.
  - FIFO empty, FSM = IDLE.
- Ingress:
  - A flit with router_in_port[35]=1 at edge N is written to the FIFO at that edge.
  - m_axis_tvalid may first assert in cycle N+1. Minimum latency is 1 cycle; there is no combinational path from input to output.
- Egress, AXI-S rules:
  - Pop on m_axis_tvalid && m_axis_tready.
  - While tvalid=1 and tready=0, tdata/tlast/tuser stay stable.
  - tvalid never deasserts without a handshake.
  - Sustained throughput is 1 flit/cycle when tready is held high.
- Credit return:
  - flow_ctrl_out pulses high for exactly one cycle, in the cycle after each pop.
  - Back-to-back pops produce back-to-back pulses.
  - No credits are issued at reset; the router starts with DEPTH credits.
- Simultaneous push and pop:
  - Both occur in the same cycle, occupancy is unchanged.
  - A push when full is legal if a pop occurs in that same cycle.
- Overflow:
  - Condition: valid flit while full and no pop.
  - The flit is dropped, err_overflow is set, no credit is ever returned for it, and FIFO contents are unchanged.
- Framing FSM, two states, evaluated on every valid incoming flit (including dropped ones):
  - IDLE, head=1 tail=1: single-flit packet, stay IDLE.
  - IDLE, head=1 tail=0: go to IN_PKT.
  - IDLE, head=0: set err_framing; the flit is still stored. If tail=0 go to IN_PKT, else stay IDLE.
  - IN_PKT, head=0 tail=1: go to IDLE.
  - IN_PKT, head=0 tail=0: stay IN_PKT.
  - IN_PKT, head=1: set err_framing; the flit is treated as a new packet head (tail=1 → IDLE, else stay IN_PKT).
- Error flags clear only on rst.
- Reset mid-operation:
  - FIFO is flushed and the FSM returns to IDLE.
  - No credits are returned for flushed flits; the router is reset on the same rst.
  - Any in-flight credit pulse is suppressed.
- Wrap-around: FIFO pointers are log2(DEPTH) bits plus a wrap bit; full/empty are derived from pointer compare.

Decomposition:
- Package noc_flit_pkg: FLIT_W, bit indices FLIT_VALID=35, FLIT_HEAD=34, FLIT_TAIL=33, FLIT_DATA_MSB=31; shared with axis_to_noc_adapter.
- Sub-module noc_rx_fifo:
  - Synchronous FIFO of width AXIW+2, depth DEPTH.
  - Ports: push, pop, full, empty, registered (first-word-fall-through) output.
- Top level holds the framing FSM, credit pulse register and error flags.

Test Plan:
1. Single flit {valid=1, head=1, tail=1, data=0xAABBCCDD}, tready=1 → one cycle later tvalid=1, tdata=0xAABBCCDD, tlast=1, tuser=1; flow_ctrl_out pulses one cycle after the handshake; no error flags.
2. 3-flit packet (head 0x11223344, body 0x55667788, tail 0xDEADBEEF) back-to-back, tready=1 → three consecutive beats in order, tuser=1/0/0, tlast=0/0/1; three consecutive credit pulses.
3. tready=0; send 8 single-flit packets (data 0..7) → FIFO full, no credit pulses, tdata=0 held stable. Raise tready → data 0..7 drained on 8 consecutive cycles; 8 credit pulses total.
4. With the FIFO full and tready=0, inject a 9th flit 0x99 → err_overflow=1; after draining, 8 beats are seen with no 0x99; exactly 8 credits returned.
5. Framing: body flit (head=0, tail=0) while IDLE → err_framing=1 and the flit is delivered with tuser=0. Then head (tail=0) followed by another head → err_framing remains 1, and both flits are delivered.
6. Assert rst for 1 cycle with 4 flits buffered and tready=0 → next cycle tvalid=0, flags=0, no credit pulses. A fresh single-flit packet 0x5 is then delivered normally.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Flit field layout shared by the NoC/AXI-Stream adapters.
package noc_flit_pkg;
    localparam int FLIT_W        = 36;
    localparam int FLIT_VALID    = 35;
    localparam int FLIT_HEAD     = 34;
    localparam int FLIT_TAIL     = 33;
    localparam int FLIT_RSVD     = 32;
    localparam int FLIT_DATA_MSB = 31;

    typedef enum logic {
        FR_IDLE   = 1'b0,
        FR_IN_PKT = 1'b1
    } frame_state_t;
endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
module noc_rx_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_next, rd_next;
    logic         do_push, do_pop, empty_next;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign wr_next    = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_next    = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    assign empty_next = (wr_next == rd_next);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // dout is preloaded with the entry that will be at the head after this edge;
    // if that entry is being written right now it has to come from din.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (!empty_next) begin
                if (do_push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) dout <= din;
                else                                                 dout <= mem[rd_next[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/noc_to_axis_adapter.sv
// Egress adapter: router ejection port flits -> AXI-Stream master with credit return.
// state     | meaning
// FR_IDLE   | between packets, next valid flit should be a head
// FR_IN_PKT | inside a packet, next valid flit should be body or tail
module noc_to_axis_adapter
    import noc_flit_pkg::*;
#(
    parameter int AXIW   = 32,
    parameter int DEPTH  = 8,
    parameter int FLIT_W = noc_flit_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] router_in_port,
    output logic              flow_ctrl_out,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [AXIW-1:0]   m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              err_overflow,
    output logic              err_framing
);
    logic              flit_valid, flit_head, flit_tail;
    logic              fifo_full, fifo_empty, pop;
    logic [AXIW+1:0]   fifo_dout;
    logic              unused_rsvd;
    frame_state_t      state, state_next;
    logic              frame_err;

    assign flit_valid  = router_in_port[FLIT_VALID];
    assign flit_head   = router_in_port[FLIT_HEAD];
    assign flit_tail   = router_in_port[FLIT_TAIL];
    assign unused_rsvd = router_in_port[FLIT_RSVD];

    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tuser  = fifo_dout[AXIW+1];
    assign m_axis_tlast  = fifo_dout[AXIW];
    assign m_axis_tdata  = fifo_dout[AXIW-1:0];

    noc_rx_fifo #(.W(AXIW+2), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (flit_valid),
        .din   ({flit_head, flit_tail, router_in_port[AXIW-1:0]}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FR_IDLE;
        else     state <= state_next;
    end

    // Dropped (overflow) flits still advance framing: the sender's packet stream
    // continues regardless of whether this port kept the flit.
    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        if (flit_valid) begin
            case (state)
                FR_IDLE: begin
                    frame_err  = !flit_head;
                    state_next = flit_tail ? FR_IDLE : FR_IN_PKT;
                end
                FR_IN_PKT: begin
                    frame_err  = flit_head;
                    state_next = flit_tail ? FR_IDLE : FR_IN_PKT;
                end
                default: state_next = FR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flow_ctrl_out <= 1'b0;
            err_overflow  <= 1'b0;
            err_framing   <= 1'b0;
        end else begin
            flow_ctrl_out <= pop;
            if (flit_valid && fifo_full && !pop) err_overflow <= 1'b1;
            if (frame_err)                       err_framing  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_to_axis_adapter.sv
// Bench for noc_to_axis_adapter: queue-based reference model plus directed scenarios.
module tb_noc_to_axis_adapter;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] router_in_port = '0;
    logic        flow_ctrl_out, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        err_overflow, err_framing;

    int checks = 0;
    int failures = 0;

    noc_to_axis_adapter #(.AXIW(32), .DEPTH(DEPTH), .FLIT_W(36)) dut (
        .clk            (clk),
        .rst            (rst),
        .router_in_port (router_in_port),
        .flow_ctrl_out  (flow_ctrl_out),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .err_overflow   (err_overflow),
        .err_framing    (err_framing)
    );

    always #5 clk = ~clk;

    // Reference model: entries are {head, tail, data}
    logic [33:0] mq[$];
    logic        m_credit = 1'b0, m_ovf = 1'b0, m_frm = 1'b0, m_in_pkt = 1'b0;
    logic        model_live = 1'b0;

    // Observed stream (for literal checks)
    logic [33:0] beats[$];
    int          credits_seen = 0;

    always @(posedge clk) begin
        logic pop_now;
        logic [33:0] f;
        if (model_live && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (model_live && flow_ctrl_out) credits_seen++;
        if (rst) begin
            mq.delete();
            m_credit = 1'b0; m_ovf = 1'b0; m_frm = 1'b0; m_in_pkt = 1'b0;
            model_live = 1'b1;
        end else begin
            pop_now = (mq.size() > 0) && m_axis_tready;
            m_credit = pop_now;
            if (pop_now) void'(mq.pop_front());
            if (router_in_port[35]) begin
                f = {router_in_port[34], router_in_port[33], router_in_port[31:0]};
                if (m_in_pkt == router_in_port[34]) m_frm = 1'b1;
                m_in_pkt = !router_in_port[33];
                if (mq.size() >= DEPTH) m_ovf = 1'b1;
                else mq.push_back(f);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_live) begin
            checks++;
            if (m_axis_tvalid !== (mq.size() > 0)) begin
                failures++;
                $display("FAIL tvalid: got %b want %b", m_axis_tvalid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== mq[0]) begin
                    failures++;
                    $display("FAIL beat: got u=%b l=%b d=%h want %h",
                             m_axis_tuser, m_axis_tlast, m_axis_tdata, mq[0]);
                end
            end
            checks++;
            if (flow_ctrl_out !== m_credit) begin
                failures++;
                $display("FAIL credit: got %b want %b", flow_ctrl_out, m_credit);
            end
            checks++;
            if ({err_overflow, err_framing} !== {m_ovf, m_frm}) begin
                failures++;
                $display("FAIL flags: got ovf=%b frm=%b want ovf=%b frm=%b",
                         err_overflow, err_framing, m_ovf, m_frm);
            end
        end
    end

    function automatic logic [35:0] mk(input logic h, input logic t, input logic [31:0] d);
        return {1'b1, h, t, 1'b0, d};
    endfunction

    task automatic cyc(input logic [35:0] f, input logic rdy);
        @(negedge clk);
        router_in_port = f;
        m_axis_tready  = rdy;
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    int c0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lit("reset_outputs", {m_axis_tvalid, flow_ctrl_out, err_overflow, err_framing, m_axis_tdata}, 0);

        // 1: single flit
        beats.delete(); c0 = credits_seen;
        cyc(mk(1, 1, 32'hAABBCCDD), 1);
        cyc('0, 1);
        lit("t1_valid_lat1", m_axis_tvalid, 1);
        lit("t1_data", m_axis_tdata, 32'hAABBCCDD);
        lit("t1_last_user", {m_axis_tlast, m_axis_tuser}, 2'b11);
        cyc('0, 1);
        lit("t1_credit_pulse", flow_ctrl_out, 1);
        cyc('0, 1);
        lit("t1_credit_once", flow_ctrl_out, 0);
        lit("t1_credits", credits_seen - c0, 1);

        // 2: 3-flit packet back-to-back
        beats.delete(); c0 = credits_seen;
        cyc(mk(1, 0, 32'h11223344), 1);
        cyc(mk(0, 0, 32'h55667788), 1);
        cyc(mk(0, 1, 32'hDEADBEEF), 1);
        repeat (4) cyc('0, 1);
        lit("t2_nbeats", beats.size(), 3);
        if (beats.size() == 3) begin
            lit("t2_b0", beats[0], {2'b10, 32'h11223344});
            lit("t2_b1", beats[1], {2'b00, 32'h55667788});
            lit("t2_b2", beats[2], {2'b01, 32'hDEADBEEF});
        end
        lit("t2_credits", credits_seen - c0, 3);

        // 3+4: fill with tready low, overflow, then drain
        beats.delete(); c0 = credits_seen;
        for (int i = 0; i < 8; i++) cyc(mk(1, 1, i), 0);
        cyc(mk(1, 1, 32'h99), 0);
        cyc('0, 0);
        lit("t3_full_hold_data", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h0});
        lit("t4_overflow", err_overflow, 1);
        lit("t3_no_credits", credits_seen - c0, 0);
        for (int i = 0; i < 10; i++) cyc('0, 1);
        lit("t4_nbeats", beats.size(), 8);
        for (int i = 0; i < 8 && i < beats.size(); i++)
            lit("t3_drain_data", beats[i], {2'b11, 32'(i)});
        lit("t4_credits", credits_seen - c0, 8);

        // 5: framing violations
        beats.delete();
        cyc(mk(0, 0, 32'hB0D1), 1);
        cyc('0, 1);
        lit("t5_frm_body_idle", err_framing, 1);
        cyc(mk(1, 0, 32'hA1), 1);
        cyc(mk(1, 0, 32'hA2), 1);
        cyc(mk(0, 1, 32'hA3), 1);
        repeat (3) cyc('0, 1);
        lit("t5_frm_sticky", err_framing, 1);
        lit("t5_nbeats", beats.size(), 4);
        if (beats.size() == 4) begin
            lit("t5_b0_user0", beats[0], {2'b00, 32'hB0D1});
            lit("t5_b1", beats[1], {2'b10, 32'hA1});
            lit("t5_b2", beats[2], {2'b10, 32'hA2});
        end

        // 6: reset with flits buffered
        for (int i = 0; i < 4; i++) cyc(mk(1, 1, 32'h40 + i), 0);
        cyc('0, 0);
        rst = 1'b1;
        cyc('0, 0);
        rst = 1'b0;
        lit("t6_after_rst", {m_axis_tvalid, flow_ctrl_out, err_overflow, err_framing}, 0);
        beats.delete(); c0 = credits_seen;
        cyc('0, 1);
        lit("t6_no_credit", flow_ctrl_out, 0);
        cyc(mk(1, 1, 32'h5), 1);
        repeat (3) cyc('0, 1);
        lit("t6_nbeats", beats.size(), 1);
        if (beats.size() == 1) lit("t6_beat", beats[0], {2'b11, 32'h5});
        lit("t6_credits", credits_seen - c0, 1);

        // randomised-ready stress through the model
        for (int i = 0; i < 200; i++)
            cyc(($urandom_range(0, 2) != 0) ? mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom) : 36'h0, 1'($urandom_range(0, 1)));
        repeat (12) cyc('0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
